keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 23 ++
 rtl/synchronizer.sv | 28 ++
 rtl/keypad_scanner.sv | 177 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    // 100 us column dwell and 20 ms debounce at 48 MHz
    localparam int unsigned SCAN_COUNT_DEFAULT     = 4800;
    localparam int unsigned DEBOUNCE_COUNT_DEFAULT = 960000;

    typedef enum logic [1:0] {
        StScan,
        StDebouncePress,
        StHeld,
        StDebounceRelease
    } state_e;

    // Indexed [row][col]; row 0 is the top row, col 0 the leftmost column
    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

endpackage

// File: rtl/synchronizer.sv
// Two-flop synchronizer for asynchronous multi-bit level inputs.
module synchronizer #(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // First flop may go metastable; second flop gives it a cycle to settle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column, debounces press and
// release, and reports each accepted key once along with the previous key.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_COUNT     = SCAN_COUNT_DEFAULT,
    parameter int unsigned DEBOUNCE_COUNT = DEBOUNCE_COUNT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       key_valid,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old
);

    localparam int unsigned       SCAN_W    = $clog2(SCAN_COUNT);
    localparam int unsigned       DEB_W     = $clog2(DEBOUNCE_COUNT);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_COUNT - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_COUNT - 1);

    state_e              state_q, state_d;
    logic [1:0]          col_q, col_d;
    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
    logic [3:0]          pat_q, pat_d;
    logic [3:0]          key_q, key_d;
    logic                key_valid_q, key_valid_d;
    logic [3:0]          digit_new_q, digit_new_d;
    logic [3:0]          digit_old_q, digit_old_d;

    logic [3:0]          rows_sync;
    logic [3:0]          low_rows;
    logic                single_low;
    logic [1:0]          row_idx;
    logic [3:0]          key_code;

    synchronizer #(
        .WIDTH       (4),
        .RESET_VALUE (4'b1111)
    ) u_rows_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rows),
        .q     (rows_sync)
    );

    // Latched pattern has exactly one low row when low_rows is a power of two
    assign low_rows   = ~pat_q;
    assign single_low = (low_rows != 4'h0) && ((low_rows & (low_rows - 4'd1)) == 4'h0);

    // Row number of the lowest-numbered low row in the latched pattern
    always_comb begin
        row_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (low_rows[i]) begin
                row_idx = 2'(i);
            end
        end
    end

    assign key_code = KEY_MAP[row_idx][col_q];

    // Next-state, counter and key-register logic for the scan/debounce FSM
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        scan_cnt_d  = scan_cnt_q;
        deb_cnt_d   = deb_cnt_q;
        pat_d       = pat_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        digit_new_d = digit_new_q;
        digit_old_d = digit_old_q;

        case (state_q)
            StScan: begin
                if (scan_cnt_q == SCAN_LAST) begin
                    scan_cnt_d = '0;
                    if (rows_sync != 4'hF) begin
                        state_d   = StDebouncePress;
                        pat_d     = rows_sync;
                        deb_cnt_d = '0;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    scan_cnt_d = scan_cnt_q + 1'b1;
                end
            end

            StDebouncePress: begin
                if (rows_sync != pat_q) begin
                    state_d    = StScan;
                    col_d      = col_q + 2'd1;
                    scan_cnt_d = '0;
                    deb_cnt_d  = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    deb_cnt_d  = '0;
                    scan_cnt_d = '0;
                    if (single_low) begin
                        state_d     = StHeld;
                        key_valid_d = 1'b1;
                        key_d       = key_code;
                        digit_old_d = digit_new_q;
                        digit_new_d = key_code;
                    end else begin
                        // Multi-key chord: reject and move on
                        state_d = StScan;
                        col_d   = col_q + 2'd1;
                    end
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end

            StHeld: begin
                // Only the accepted row matters; other keys are ignored
                if (rows_sync[row_idx]) begin
                    state_d   = StDebounceRelease;
                    deb_cnt_d = '0;
                end
            end

            StDebounceRelease: begin
                if (rows_sync != 4'hF) begin
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d    = StScan;
                    col_d      = col_q + 2'd1;
                    scan_cnt_d = '0;
                    deb_cnt_d  = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = StScan;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StScan;
            col_q       <= 2'd0;
            scan_cnt_q  <= '0;
            deb_cnt_q   <= '0;
            pat_q       <= 4'hF;
            key_q       <= 4'h0;
            key_valid_q <= 1'b0;
            digit_new_q <= 4'h0;
            digit_old_q <= 4'h0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            scan_cnt_q  <= scan_cnt_d;
            deb_cnt_q   <= deb_cnt_d;
            pat_q       <= pat_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            digit_new_q <= digit_new_d;
            digit_old_q <= digit_old_d;
        end
    end

    assign cols      = ~(4'b0001 << col_q);
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign digit_new = digit_new_q;
    assign digit_old = digit_old_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a cycle-level behavioural model.
module tb_keypad_scanner;

    localparam int SC = 4;
    localparam int DC = 8;

    logic       clk;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key;
    logic       key_valid;
    logic [3:0] digit_new;
    logic [3:0] digit_old;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int back2back = 0;
    logic kv_prev = 1'b0;

    keypad_scanner #(
        .SCAN_COUNT     (SC),
        .DEBOUNCE_COUNT (DC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .key       (key),
        .key_valid (key_valid),
        .digit_new (digit_new),
        .digit_old (digit_old)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    // mode: 0 scanning, 1 confirming press, 2 key down, 3 confirming release
    int         m_mode, m_base, m_t, m_col, m_run, m_row;
    logic [3:0] m_pat, h1, h2, e_key, e_dn, e_do, rs;
    logic       e_kv;
    int         km [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    // While scanning, the column follows from elapsed time since the scan began
    function automatic int scan_col();
        return (m_base + m_t / SC) % 4;
    endfunction

    function automatic logic [3:0] exp_cols();
        int c;
        logic [3:0] one;
        one = 4'b0001;
        c = (m_mode == 0) ? scan_col() : m_col;
        return ~(one << c);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_base = 0; m_t = 0; m_col = 0; m_run = 0; m_row = 0;
        m_pat = 4'hF; h1 = 4'hF; h2 = 4'hF;
        e_key = 4'h0; e_dn = 4'h0; e_do = 4'h0; e_kv = 1'b0;
    endtask

    task automatic resume_scan();
        m_base = (m_col + 1) % 4;
        m_t    = 0;
        m_mode = 0;
    endtask

    task automatic model_step(input logic [3:0] s);
        int k;
        e_kv = 1'b0;
        case (m_mode)
            0: begin
                if ((m_t % SC) == SC - 1 && s != 4'hF) begin
                    m_col = scan_col(); m_pat = s; m_run = 0; m_mode = 1;
                end else begin
                    m_t++;
                end
            end
            1: begin
                if (s != m_pat) resume_scan();
                else begin
                    m_run++;
                    if (m_run == DC) begin
                        if ($countones(~m_pat) == 1) begin
                            for (int r = 3; r >= 0; r--) if (!m_pat[r]) m_row = r;
                            k = km[m_row * 4 + m_col];
                            e_do = e_dn; e_dn = 4'(k); e_key = 4'(k); e_kv = 1'b1;
                            m_mode = 2;
                        end else begin
                            resume_scan();
                        end
                    end
                end
            end
            2: begin
                if (s[m_row]) begin m_mode = 3; m_run = 0; end
            end
            default: begin
                if (s == 4'hF) begin
                    m_run++;
                    if (m_run == DC) resume_scan();
                end else begin
                    m_run = 0;
                end
            end
        endcase
    endtask

    // Model sees the rows the bench drove two edges ago
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else begin
                rs = h2; h2 = h1; h1 = rows;
                model_step(rs);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [16:0] act_v, exp_v;
    initial begin
        forever begin
            @(negedge clk);
            act_v = {cols, key, key_valid, digit_new, digit_old};
            exp_v = {exp_cols(), e_key, e_kv, e_dn, e_do};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL per_cycle t=%0t actual cols=%b key=%h kv=%b dn=%h do=%h required cols=%b key=%h kv=%b dn=%h do=%h",
                         $time, cols, key, key_valid, digit_new, digit_old,
                         exp_v[16:13], exp_v[12:9], exp_v[8], exp_v[7:4], exp_v[3:0]);
            end
            if (key_valid === 1'b1) pulses++;
            if (key_valid === 1'b1 && kv_prev === 1'b1) back2back++;
            kv_prev = key_valid;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Wait for the start of a fresh dwell on column pattern c
    task automatic wait_col_start(input logic [3:0] c, input string name);
        int n;
        n = 0;
        while (cols == c && n < 100) begin step(1); n++; end
        while (cols != c && n < 100) begin step(1); n++; end
        chk(name, 32'(n < 100), 32'd1);
    endtask

    task automatic press(input logic [3:0] pattern, input int hold, input int settle);
        rows = pattern;
        step(hold);
        rows = 4'hF;
        step(settle);
    endtask

    logic [3:0] seq [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        rows  = 4'hF;
        step(3);
        chk("rst_cols", cols, 4'b1110);
        chk("rst_key", key, 4'h0);
        chk("rst_kv", key_valid, 1'b0);
        chk("rst_dn", digit_new, 4'h0);
        chk("rst_do", digit_old, 4'h0);

        // Idle scan: each column held SC cycles
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("scan_seq%0d", i), cols, seq[i / 4]);
            step(1);
        end
        chk("idle_no_pulse", pulses, 0);

        // Key "8": row 2 on column 1
        wait_col_start(4'b1101, "wait_col1");
        rows = 4'b1011;
        step(40);
        chk("k8_held_cols", cols, 4'b1101);
        chk("k8_pulses", pulses, 1);
        chk("k8_key", key, 4'h8);
        chk("k8_dn", digit_new, 4'h8);
        chk("k8_do", digit_old, 4'h0);
        rows = 4'hF;
        step(4);
        chk("k8_release_cols", cols, 4'b1101);
        step(8);
        chk("k8_next_col", cols, 4'b1011);

        // "5" then "A"
        wait_col_start(4'b1101, "wait_5");
        press(4'b1101, 20, 20);
        wait_col_start(4'b0111, "wait_A");
        press(4'b1110, 20, 20);
        chk("5A_pulses", pulses, 3);
        chk("5A_key", key, 4'hA);
        chk("5A_dn", digit_new, 4'hA);
        chk("5A_do", digit_old, 4'h5);

        // Bouncing row 0 on column 0
        wait_col_start(4'b1110, "wait_bounce");
        for (int i = 0; i < 5; i++) press(4'b1110, 3, 2);
        step(20);
        chk("bounce_pulses", pulses, 3);
        chk("bounce_key", key, 4'hA);
        wait_col_start(4'b1101, "bounce_scan_resumes");

        // Two rows low on column 3
        wait_col_start(4'b0111, "wait_chord");
        press(4'b0011, 20, 20);
        chk("chord_pulses", pulses, 3);

        // "D", then reset while held
        wait_col_start(4'b0111, "wait_D");
        rows = 4'b0111;
        step(20);
        chk("D_pulses", pulses, 4);
        chk("D_key", key, 4'hD);
        chk("D_dn", digit_new, 4'hD);
        chk("D_do", digit_old, 4'hA);
        chk("D_held_cols", cols, 4'b0111);
        reset = 1'b0;
        #1;
        chk("midrst_cols", cols, 4'b1110);
        chk("midrst_key", key, 4'h0);
        chk("midrst_kv", key_valid, 1'b0);
        chk("midrst_dn", digit_new, 4'h0);
        chk("midrst_do", digit_old, 4'h0);
        rows = 4'hF;
        step(3);
        reset = 1'b1;
        step(2);
        chk("post_rst_cols", cols, 4'b1110);
        chk("post_rst_pulses", pulses, 4);
        chk("no_back_to_back", back2back, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench timeout");
    end

endmodule
